data_memory_reader: RTL and testbench

Sequential read master for the `data_memory` block: on a start command it walks a contiguous address range, issues one `Rd` per word, and streams the returned words out on a valid/ready interface with full backpressure. It sits between `data_memory` and any consumer of memory contents, such as a debug dump path or a block transfer into another unit. It never writes; the memory's `Wr` input is tied low while this block owns the port.

---
 rtl/data_memory_reader.sv | 116 +++++++++++
 tb/tb_data_memory_reader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_reader.sv
// Sequential read master: walks an address range in data_memory and streams each word out.
// Latency: first o_valid 2 cycles after the start edge; 3 cycles per word with i_ready held high.
// Backpressure: o_valid/o_data hold until i_ready; no new read is issued until the handshake.
module data_memory_reader #(
    parameter int B = 16,
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_start,
    input  logic [W-1:0] i_base_addr,
    input  logic [W:0]   i_count,
    output logic         o_Rd,
    output logic [W-1:0] o_Addr,
    input  logic [B-1:0] i_mem_data,
    output logic [B-1:0] o_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic         o_busy,
    output logic         o_done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_WAIT = 3'd2,
        S_SEND = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   addr_q,  addr_d;
    logic [W:0]     rem_q,   rem_d;
    logic [B-1:0]   data_q,  data_d;

    // State register; reset abandons any word in flight without a done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one READ/WAIT/SEND round per word, DONE once the counter is exhausted.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = (i_count == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: state_d = S_WAIT;
            S_WAIT: state_d = S_SEND;
            S_SEND: begin
                if (i_ready) begin
                    state_d = (rem_q > (W+1)'(1)) ? S_READ : S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath registers: address, remaining-word counter and the output word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
            rem_q  <= '0;
            data_q <= '0;
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
            data_q <= data_d;
        end
    end

    // Datapath next-state: latch the command in IDLE, capture memory data in WAIT,
    // advance on each handshake. The address is left alone after the last word so
    // o_Addr keeps showing the final address read.
    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        data_d = data_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    addr_d = i_base_addr;
                    rem_d  = i_count;
                end
            end
            S_WAIT: data_d = i_mem_data;
            S_SEND: begin
                if (i_ready) begin
                    rem_d = rem_q - (W+1)'(1);
                    if (rem_q > (W+1)'(1)) begin
                        addr_d = addr_q + W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // Outputs decode purely from registered state and datapath.
    always_comb begin
        o_Rd    = (state_q == S_READ);
        o_Addr  = addr_q;
        o_data  = data_q;
        o_valid = (state_q == S_SEND);
        o_busy  = (state_q != S_IDLE);
        o_done  = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_data_memory_reader.sv
// Bench for data_memory_reader: registered-read memory model, table of directed transfers,
// randomized transfers against a transaction-level reference, and reset corner cases.
// All waits are bounded; results are tallied into one summary line.
module tb_data_memory_reader;

    logic        clk;
    logic        reset;
    logic        i_start;
    logic [10:0] i_base_addr;
    logic [11:0] i_count;
    logic        o_Rd;
    logic [10:0] o_Addr;
    logic [15:0] i_mem_data;
    logic [15:0] o_data;
    logic        o_valid;
    logic        i_ready;
    logic        o_busy;
    logic        o_done;

    int checks = 0;
    int fails  = 0;

    data_memory_reader #(.B(16), .W(11)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_count     (i_count),
        .o_Rd        (o_Rd),
        .o_Addr      (o_Addr),
        .i_mem_data  (i_mem_data),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: Rd/Addr sampled on a rising edge, data valid the following cycle.
    logic [15:0] mem [0:2047];
    logic [15:0] mem_out = 16'h0;
    always @(posedge clk) begin
        if (o_Rd) mem_out <= mem[o_Addr];
    end
    assign i_mem_data = mem_out;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one transfer and checks it against the reference: word i comes from
    // mem[(base+i) mod 2048], the i-th read targets that address, and done arrives
    // 3 cycles per word plus one per stalled valid cycle after the start edge.
    // mode: 0 ready always high, 1 random ready, 2 ready low for 5 cycles after the first valid.
    task automatic do_transfer(input logic [10:0] base, input logic [11:0] cnt, input int mode,
                               input int glitch, input int exp_done, input string tag,
                               output logic [15:0] first_word);
        logic [15:0] got [$];
        logic [10:0] rds [$];
        int k, stalls, done_k, first_v, bp_left, limit, exp_k;
        int busy_err, stab_err, rd_err;
        logic prev_v, prev_hs, hs;
        logic [15:0] prev_d;
        logic [10:0] ea;
        k = 0; stalls = 0; done_k = -1; first_v = -1; bp_left = 5;
        busy_err = 0; stab_err = 0; rd_err = 0;
        prev_v = 1'b0; prev_hs = 1'b0; prev_d = 16'h0;
        limit = 3 * int'(cnt) + 200;

        @(negedge clk);
        i_start = 1'b1; i_base_addr = base; i_count = cnt; i_ready = 1'b1;
        while (done_k < 0 && k < limit) begin
            @(negedge clk);
            if (o_busy !== 1'b1) busy_err++;
            if (o_Rd === 1'b1) begin
                if (rds.size() != got.size()) rd_err++;
                rds.push_back(o_Addr);
            end
            if (prev_v && !prev_hs && (o_valid !== 1'b1 || o_data !== prev_d)) stab_err++;
            if (o_valid === 1'b1 && first_v < 0) first_v = k;
            if (o_done === 1'b1) begin
                done_k = k;
            end else begin
                i_start = (k == glitch);
                if (k == glitch) begin
                    i_base_addr = base ^ 11'h155;
                    i_count     = 12'd7;
                end
                case (mode)
                    0: i_ready = 1'b1;
                    1: i_ready = ($urandom_range(0, 2) != 0);
                    default: begin
                        if (o_valid === 1'b1 && bp_left > 0) begin
                            i_ready = 1'b0;
                            bp_left--;
                        end else begin
                            i_ready = 1'b1;
                        end
                    end
                endcase
                hs = (o_valid === 1'b1) && i_ready;
                if (hs) got.push_back(o_data);
                if (o_valid === 1'b1 && !i_ready) stalls++;
                prev_v  = (o_valid === 1'b1);
                prev_d  = o_data;
                prev_hs = hs;
                k++;
            end
        end
        i_start = 1'b0;

        @(negedge clk);
        chk({tag, "_idle_after"}, {30'd0, o_busy, o_done}, 32'd0);

        exp_k = (exp_done >= 0) ? exp_done : 3 * int'(cnt) + stalls;
        chk({tag, "_done_cycle"}, done_k, exp_k);
        chk({tag, "_rd_count"}, rds.size(), int'(cnt));
        chk({tag, "_word_count"}, got.size(), int'(cnt));
        for (int i = 0; i < int'(cnt); i++) begin
            ea = base + 11'(i);
            if (i < rds.size()) chk($sformatf("%s_addr%0d", tag, i), rds[i], ea);
            if (i < got.size()) chk($sformatf("%s_word%0d", tag, i), got[i], mem[ea]);
        end
        chk({tag, "_busy_err"}, busy_err, 0);
        chk({tag, "_stable_err"}, stab_err, 0);
        chk({tag, "_rd_outstanding"}, rd_err, 0);
        if (cnt != 12'd0) chk({tag, "_first_valid"}, first_v, 2);
        else              chk({tag, "_no_valid"}, first_v, -1);
        first_word = (got.size() > 0) ? got[0] : 16'h0;
    endtask

    typedef struct {
        logic [10:0] base;
        logic [11:0] cnt;
        int          mode;
        int          glitch;
        int          exp_done;
        logic [15:0] exp_first;
    } vec_t;

    vec_t vecs [6];
    logic [15:0] fw;
    int          done_seen;

    initial begin
        reset = 1'b1; i_start = 1'b0; i_base_addr = '0; i_count = '0; i_ready = 1'b0;
        for (int i = 0; i < 2048; i++) mem[i] = 16'($urandom);
        mem[11'h002] = 16'h0F0F;
        mem[11'h7FE] = 16'hAAAA;
        mem[11'h7FF] = 16'hBBBB;
        mem[11'h000] = 16'hCCCC;
        mem[11'h010] = 16'h1234;
        mem[11'h040] = 16'h4040;
        mem[11'h005] = 16'h0505;

        vecs[0] = '{11'h002, 12'd1,    0, -1, 3,    16'h0F0F};
        vecs[1] = '{11'h7FE, 12'd3,    0, -1, 9,    16'hAAAA};
        vecs[2] = '{11'h010, 12'd2,    2, -1, 11,   16'h1234};
        vecs[3] = '{11'h020, 12'd0,    0, -1, 0,    16'h0000};
        vecs[4] = '{11'h040, 12'd4,    0,  4, 12,   16'h4040};
        vecs[5] = '{11'h005, 12'd2048, 0, -1, 6144, 16'h0505};

        #3;
        chk("reset_outputs", {1'b0, o_Rd, o_Addr, o_data, o_valid, o_busy, o_done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_release_busy", {31'd0, o_busy}, 32'd0);

        for (int v = 0; v < 6; v++) begin
            do_transfer(vecs[v].base, vecs[v].cnt, vecs[v].mode, vecs[v].glitch,
                        vecs[v].exp_done, $sformatf("vec%0d", v), fw);
            chk($sformatf("vec%0d_first_word", v), fw, vecs[v].exp_first);
        end

        // Reset asserted between edges during the second WAIT of a 4-word burst.
        @(negedge clk);
        i_start = 1'b1; i_base_addr = 11'h100; i_count = 12'd4; i_ready = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_mid_state", {29'd0, o_busy, o_Rd, o_valid}, 32'h4);
        #2 reset = 1'b1;
        #1 chk("rst_async_outputs", {1'b0, o_Rd, o_Addr, o_data, o_valid, o_busy, o_done}, 32'd0);
        done_seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (o_done !== 1'b0) done_seen++;
        end
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (o_done !== 1'b0 || o_busy !== 1'b0) done_seen++;
        end
        chk("rst_no_done", done_seen, 0);
        do_transfer(11'h300, 12'd1, 0, -1, 3, "post_rst", fw);
        chk("post_rst_first_word", fw, mem[11'h300]);

        // Randomized transfers with random backpressure and stray start pulses.
        for (int r = 0; r < 20; r++) begin
            do_transfer(11'($urandom_range(0, 2047)), 12'($urandom_range(0, 8)), 1,
                        ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 10)) : -1,
                        -1, $sformatf("rnd%0d", r), fw);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
